// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family.
package counter_pkg;

  localparam int MAX_WIDTH = 16;

  // Returns a MAX_WIDTH vector with the low w bits set.
  function automatic logic [MAX_WIDTH-1:0] all_ones(input int w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// One counter bit: toggles on t, loads set_val on ld, falling-edge clocked.
module tff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic set_val,
  input  logic ld,
  output logic q
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld)     q_d = set_val;
    else if (t) q_d = ~q_q;
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) q_q <= RST_VAL;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/up_counter.sv
// Loadable up counter built from toggle cells; registered tc and wrap flags.
// Define UP_COUNTER_SAT_EN to saturate at all-ones instead of wrapping.
module up_counter
  import counter_pkg::*;
#(
  parameter int          WIDTH = 3,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [MAX_WIDTH-1:0] ONES_FULL = all_ones(WIDTH);
  localparam logic [WIDTH-1:0]     ONES      = ONES_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     PRE_MAX   = {ONES[WIDTH-1:1], 1'b0};
  localparam logic [31:0]          INIT_FULL = INIT;
  localparam logic [WIDTH-1:0]     INIT_V    = INIT_FULL[WIDTH-1:0];

  logic             at_max, inc;
  logic [WIDTH-1:0] t;
  logic             tc_q, tc_d, wrap_q, wrap_d;

  assign at_max = (q == ONES);

`ifdef UP_COUNTER_SAT_EN
  assign inc    = en & ~at_max;
  assign wrap_d = 1'b0;
`else
  assign inc    = en;
  assign wrap_d = ~ld & en & at_max;
`endif

  // Ripple toggle enables: bit i flips when all lower bits are one.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lsb
        assign t[i] = inc;
      end else begin : g_up
        assign t[i] = t[i-1] & q[i-1];
      end
      tff_cell #(.RST_VAL(INIT_V[i])) u_cell (
        .clk     (clk),
        .rst     (rst),
        .t       (t[i]),
        .set_val (d[i]),
        .ld      (ld),
        .q       (q[i])
      );
    end
  endgenerate

  // tc predicted from the same next-state priority the cells use.
  always_comb begin
    tc_d = at_max;
    if (ld)       tc_d = (d == ONES);
    else if (inc) tc_d = (q == PRE_MAX);
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      tc_q   <= (INIT_V == ONES);
      wrap_q <= 1'b0;
    end else begin
      tc_q   <= tc_d;
      wrap_q <= wrap_d;
    end
  end

  assign tc   = tc_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_up_counter.sv
// Scoreboard bench for up_counter: WIDTH=3/INIT=0 and WIDTH=4/INIT=15 instances.
module tb_up_counter;

`ifdef UP_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b1;
  logic       rst = 1'b0;
  logic       enA = 1'b0, ldA = 1'b0, enB = 1'b0, ldB = 1'b0;
  logic [2:0] dA = '0, qA;
  logic [3:0] dB = '0, qB;
  logic       tcA, wrA, tcB, wrB;

  up_counter #(.WIDTH(3), .INIT(0)) dutA (
    .clk(clk), .rst(rst), .en(enA), .ld(ldA), .d(dA), .q(qA), .tc(tcA), .wrap(wrA)
  );
  up_counter #(.WIDTH(4), .INIT(15)) dutB (
    .clk(clk), .rst(rst), .en(enB), .ld(ldB), .d(dB), .q(qB), .tc(tcB), .wrap(wrB)
  );

  always #5 clk = ~clk;

  typedef struct {int q; bit tc; bit wr; string tag;} exp_t;
  exp_t sbA[$], sbB[$];
  exp_t eA, eB;
  int   checks = 0, errors = 0;
  int   mA = 0, mB = 15;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: integer counter following load > enable > hold.
  task automatic model(inout int m, input int w, input bit l, input bit e,
                       input int dv, output bit wr);
    int mx;
    mx = (1 << w) - 1;
    wr = 1'b0;
    if (l) m = dv;
    else if (e) begin
      if (m == mx) begin
        if (!SAT) begin m = 0; wr = 1'b1; end
      end else m = m + 1;
    end
  endtask

  always @(posedge clk) begin
    if (sbA.size() > 0) begin
      eA = sbA.pop_front();
      chk({eA.tag, ".qA"}, int'(qA), eA.q);
      chk({eA.tag, ".tcA"}, int'(tcA), int'(eA.tc));
      chk({eA.tag, ".wrapA"}, int'(wrA), int'(eA.wr));
    end
    if (sbB.size() > 0) begin
      eB = sbB.pop_front();
      chk({eB.tag, ".qB"}, int'(qB), eB.q);
      chk({eB.tag, ".tcB"}, int'(tcB), int'(eB.tc));
      chk({eB.tag, ".wrapB"}, int'(wrB), int'(eB.wr));
    end
  end

  // One falling edge; unit u gets (l,e,dv), the other unit idles.
  task automatic step(input int u, input bit l, input bit e, input int dv, input string tag);
    bit   wa, wb;
    exp_t x;
    @(posedge clk); #1;
    ldA = (u == 0) & l; enA = (u == 0) & e; dA = dv[2:0];
    ldB = (u == 1) & l; enB = (u == 1) & e; dB = dv[3:0];
    @(negedge clk); #1;
    model(mA, 3, (u == 0) & l, (u == 0) & e, dv & 7, wa);
    model(mB, 4, (u == 1) & l, (u == 1) & e, dv & 15, wb);
    x.q = mA; x.tc = (mA == 7);  x.wr = wa; x.tag = tag; sbA.push_back(x);
    x.q = mB; x.tc = (mB == 15); x.wr = wb; x.tag = tag; sbB.push_back(x);
    ldA = 0; enA = 0; ldB = 0; enB = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".qA"}, int'(qA), 0);
    chk({tag, ".tcA"}, int'(tcA), 0);
    chk({tag, ".wrapA"}, int'(wrA), 0);
    chk({tag, ".qB"}, int'(qB), 15);
    chk({tag, ".tcB"}, int'(tcB), 1);
    chk({tag, ".wrapB"}, int'(wrB), 0);
  endtask

  // Wait past the next posedge so the monitor has drained pending entries.
  task automatic drain();
    @(posedge clk); #2;
  endtask

  initial begin : main
    int sat_exp[5];
    sat_exp = '{6, 7, 7, 7, 7};

    // Reset held across edges, enable ignored.
    enA = 1; enB = 1;
    repeat (3) @(negedge clk);
    #1 chk_reset("in_reset");
    enA = 0; enB = 0;
    @(posedge clk); #1 rst = 1;
    mA = 0; mB = 15;

    step(0, 0, 1, 0, "first_en");
    step(1, 0, 1, 0, "b_wrap");
    step(1, 0, 0, 0, "b_after_wrap");

    // Nine enabled edges from zero.
    step(0, 1, 0, 0, "load0");
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, $sformatf("run%0d", i));

    // Load beats enable; load 0 at max is not a wrap.
    step(0, 1, 0, 2, "load2");
    step(0, 1, 1, 5, "ld_en");
    chk("ld_en.direct", int'(qA), 5);
    step(0, 1, 0, 7, "load7");
    step(0, 1, 0, 0, "load0_at7");
    chk("load0_at7.wrap", int'(wrA), 0);

    // Async reset mid-count at q=6.
    step(0, 1, 0, 6, "load6");
    drain();
    enA = 1;
    #1 rst = 0;
    #1 chk_reset("async_rst6");
    mA = 0; mB = 15;
    enA = 0;
    @(posedge clk); #1 rst = 1;

    // Reset right after a wrap pulse.
    step(0, 1, 0, 7, "load7b");
    step(0, 0, 1, 0, "inc_at7");
    drain();
    #1 rst = 0;
    #1 chk_reset("rst_kills_wrap");
    mA = 0; mB = 15;
    @(posedge clk); #1 rst = 1;
    step(0, 0, 0, 0, "post_rst_hold");

`ifdef UP_COUNTER_SAT_EN
    step(0, 1, 0, 5, "sat_load5");
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, $sformatf("sat%0d", i));
      chk($sformatf("sat%0d.q", i), int'(qA), sat_exp[i]);
      chk($sformatf("sat%0d.tc", i), int'(tcA), int'(sat_exp[i] == 7));
      chk($sformatf("sat%0d.wrap", i), int'(wrA), 0);
    end
    step(0, 1, 1, 3, "sat_ld_override");
`endif

    for (int i = 0; i < 400; i++)
      step(int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1), int'($urandom_range(0, 15)), "rnd");

    for (int k = 0; k < 5 && (sbA.size() > 0 || sbB.size() > 0); k++) @(posedge clk);
    #2;
    checks++;
    if (sbA.size() > 0 || sbB.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sbA.size() + sbB.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
